// File: rtl/cv32e40p_ft_pkg.sv
// Shared fault-tolerance types for the TMR voter/monitor: operating mode and
// per-replica health state.
package cv32e40p_ft_pkg;

    typedef enum logic [1:0] {
        MODE_TMR     = 2'd0,
        MODE_DMR     = 2'd1,
        MODE_SIMPLEX = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        REP_HEALTHY = 2'd0,
        REP_SUSPECT = 2'd1,
        REP_FAILED  = 2'd2
    } rep_state_e;

    localparam int unsigned MISM_W = 8;

endpackage

// File: rtl/cv32e40p_voter_replica_mon.sv
// Health tracker for one replica: saturating consecutive-mismatch counter
// driving a HEALTHY/SUSPECT/FAILED state machine.
//
// state       | meaning
// ------------+------------------------------------------------------------
// REP_HEALTHY | last counted vote agreed with the majority
// REP_SUSPECT | one or more consecutive disagreements, below threshold
// REP_FAILED  | ERR_TH consecutive disagreements; sticky until clear/reset
module cv32e40p_voter_replica_mon
    import cv32e40p_ft_pkg::*;
#(
    parameter int unsigned ERR_TH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       upd,
    input  logic       flag,
    output rep_state_e state
);

    rep_state_e              state_d;
    logic [MISM_W-1:0]       cnt;
    logic [MISM_W-1:0]       cnt_d;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state <= REP_HEALTHY;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        if (upd && state != REP_FAILED) begin
            if (flag) begin
                cnt_d = (cnt == '1) ? cnt : cnt + MISM_W'(1);
                if (32'(cnt_d) >= ERR_TH) state_d = REP_FAILED;
                else                      state_d = REP_SUSPECT;
            end else begin
                cnt_d   = '0;
                state_d = REP_HEALTHY;
            end
        end
    end

endmodule

// File: rtl/cv32e40p_tmr_voter_mon.sv
// Registered triple-modular-redundancy voter with per-replica health
// monitoring and graceful degradation TMR -> DMR -> SIMPLEX.
module cv32e40p_tmr_voter_mon
    import cv32e40p_ft_pkg::*;
#(
    parameter int unsigned L1     = 32,
    parameter int unsigned L2     = 1,
    parameter int unsigned ERR_TH = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [L1-1:0][L2-1:0]  in_1_i,
    input  logic [L1-1:0][L2-1:0]  in_2_i,
    input  logic [L1-1:0][L2-1:0]  in_3_i,
    input  logic                   valid_i,
    input  logic                   clear_i,
    output logic [L1-1:0][L2-1:0]  voted_o,
    output logic                   valid_o,
    output logic [2:0]             err_detected_o,
    output logic                   err_corrected_o,
    output logic                   err_uncorrectable_o,
    output logic [2:0]             failed_o,
    output logic [1:0]             mode_o,
    output logic [CNT_W-1:0]       corr_cnt_o
);

    typedef logic [L1-1:0][L2-1:0] word_t;

    rep_state_e  rep_state [3];
    logic [2:0]  failed;
    mode_e       mode;
    word_t       vote;
    word_t       dmr_a;
    word_t       dmr_b;
    logic [2:0]  dmr_mask;
    logic [2:0]  flags;
    logic        corrected;
    logic        uncorrectable;
    logic        upd;

    for (genvar g = 0; g < 3; g++) begin : g_rep
        cv32e40p_voter_replica_mon #(
            .ERR_TH (ERR_TH)
        ) u_mon (
            .clk   (clk),
            .rst   (rst),
            .clear (clear_i),
            .upd   (upd),
            .flag  (flags[g]),
            .state (rep_state[g])
        );
        assign failed[g] = (rep_state[g] == REP_FAILED);
    end

    // Mode comes only from registered replica state, never from the inputs.
    always_comb begin
        mode = MODE_SIMPLEX;
        if ($countones(failed) == 0)      mode = MODE_TMR;
        else if ($countones(failed) == 1) mode = MODE_DMR;
    end

    always_comb begin
        dmr_a    = in_1_i;
        dmr_b    = in_3_i;
        dmr_mask = 3'b101;
        if (failed[0]) begin
            dmr_a    = in_2_i;
            dmr_b    = in_3_i;
            dmr_mask = 3'b110;
        end else if (failed[2]) begin
            dmr_a    = in_1_i;
            dmr_b    = in_2_i;
            dmr_mask = 3'b011;
        end
    end

    always_comb begin
        vote          = in_1_i;
        flags         = 3'b000;
        corrected     = 1'b0;
        uncorrectable = 1'b0;
        case (mode)
            MODE_TMR: begin
                if (in_1_i == in_2_i && in_1_i == in_3_i) begin
                    vote = in_1_i;
                end else if (in_1_i == in_2_i) begin
                    vote      = in_1_i;
                    flags     = 3'b100;
                    corrected = 1'b1;
                end else if (in_1_i == in_3_i) begin
                    vote      = in_1_i;
                    flags     = 3'b010;
                    corrected = 1'b1;
                end else if (in_2_i == in_3_i) begin
                    vote      = in_2_i;
                    flags     = 3'b001;
                    corrected = 1'b1;
                end else begin
                    vote          = in_1_i;
                    flags         = 3'b111;
                    uncorrectable = 1'b1;
                end
            end
            MODE_DMR: begin
                vote = dmr_a;
                if (dmr_a != dmr_b) begin
                    flags         = dmr_mask;
                    uncorrectable = 1'b1;
                end
            end
            default: begin
                uncorrectable = 1'b1;
                if (!failed[0])      vote = in_1_i;
                else if (!failed[1]) vote = in_2_i;
                else if (!failed[2]) vote = in_3_i;
            end
        endcase
    end

    // Uncorrectable outcomes carry no information about which replica is bad.
    assign upd = valid_i && (mode != MODE_SIMPLEX) && !uncorrectable;

    always_ff @(posedge clk) begin
        if (rst) begin
            voted_o             <= '0;
            valid_o             <= 1'b0;
            err_detected_o      <= 3'b000;
            err_corrected_o     <= 1'b0;
            err_uncorrectable_o <= 1'b0;
        end else if (valid_i) begin
            voted_o             <= vote;
            valid_o             <= 1'b1;
            err_detected_o      <= flags;
            err_corrected_o     <= corrected;
            err_uncorrectable_o <= uncorrectable;
        end else begin
            valid_o             <= 1'b0;
            err_detected_o      <= 3'b000;
            err_corrected_o     <= 1'b0;
            err_uncorrectable_o <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            corr_cnt_o <= '0;
        end else if (valid_i && corrected && corr_cnt_o != '1) begin
            corr_cnt_o <= corr_cnt_o + CNT_W'(1);
        end
    end

    assign failed_o = failed;
    assign mode_o   = mode;

endmodule

// File: tb/tb_cv32e40p_tmr_voter_mon.sv
// Directed-vector bench for cv32e40p_tmr_voter_mon: voting, degradation,
// clear and reset behaviour with hand-computed expectations.
module tb_cv32e40p_tmr_voter_mon;

    logic              clk;
    logic              rst;
    logic [31:0][0:0]  in_1_i;
    logic [31:0][0:0]  in_2_i;
    logic [31:0][0:0]  in_3_i;
    logic              valid_i;
    logic              clear_i;
    logic [31:0][0:0]  voted_o;
    logic              valid_o;
    logic [2:0]        err_detected_o;
    logic              err_corrected_o;
    logic              err_uncorrectable_o;
    logic [2:0]        failed_o;
    logic [1:0]        mode_o;
    logic [15:0]       corr_cnt_o;

    int n_vec = 0;
    int n_err = 0;

    cv32e40p_tmr_voter_mon #(
        .L1(32), .L2(1), .ERR_TH(4), .CNT_W(16)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .in_1_i              (in_1_i),
        .in_2_i              (in_2_i),
        .in_3_i              (in_3_i),
        .valid_i             (valid_i),
        .clear_i             (clear_i),
        .voted_o             (voted_o),
        .valid_o             (valid_o),
        .err_detected_o      (err_detected_o),
        .err_corrected_o     (err_corrected_o),
        .err_uncorrectable_o (err_uncorrectable_o),
        .failed_o            (failed_o),
        .mode_o              (mode_o),
        .corr_cnt_o          (corr_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one valid vote; outputs are sampled 1 time unit after the edge.
    task automatic vote(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic clr);
        in_1_i  = a;
        in_2_i  = b;
        in_3_i  = c;
        valid_i = 1'b1;
        clear_i = clr;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        clear_i = 1'b0;
    endtask

    task automatic idle_cycle(input logic clr);
        valid_i = 1'b0;
        clear_i = clr;
        @(posedge clk);
        #1;
        clear_i = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        vote(32'h1234, 32'h5678, 32'h9abc, 1'b0);
        vote(32'h1234, 32'h1234, 32'h9abc, 1'b1);
        n_vec++;
        if (voted_o !== 32'h0) begin n_err++; $display("FAIL reset_voted got %h want 0", voted_o); end
        n_vec++;
        if ({valid_o, err_detected_o, err_corrected_o, err_uncorrectable_o} !== 6'b0) begin
            n_err++; $display("FAIL reset_flags got v=%b d=%b c=%b u=%b want all 0",
                              valid_o, err_detected_o, err_corrected_o, err_uncorrectable_o);
        end
        n_vec++;
        if ({failed_o, mode_o, corr_cnt_o} !== 21'b0) begin
            n_err++; $display("FAIL reset_state got failed=%b mode=%0d cnt=%0d want 0", failed_o, mode_o, corr_cnt_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_tmr_vote;
        idle_cycle(1'b1);
        vote(32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A4, 1'b0);
        n_vec++;
        if ({voted_o, valid_o, err_detected_o, err_corrected_o, err_uncorrectable_o} !== {32'hA5A5A5A5, 1'b1, 3'b100, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL tmr_r3 got %h v=%b d=%b c=%b u=%b want a5a5a5a5 1 100 1 0",
                              voted_o, valid_o, err_detected_o, err_corrected_o, err_uncorrectable_o);
        end
        n_vec++;
        if (corr_cnt_o !== 16'd1) begin n_err++; $display("FAIL tmr_r3_cnt got %0d want 1", corr_cnt_o); end
        idle_cycle(1'b0);
        n_vec++;
        if ({voted_o, valid_o, err_detected_o, err_corrected_o} !== {32'hA5A5A5A5, 1'b0, 3'b000, 1'b0}) begin
            n_err++; $display("FAIL idle_hold got %h v=%b d=%b c=%b want a5a5a5a5 0 000 0",
                              voted_o, valid_o, err_detected_o, err_corrected_o);
        end
        vote(32'h1, 32'h2, 32'h2, 1'b0);
        n_vec++;
        if ({voted_o, err_detected_o, err_corrected_o, corr_cnt_o} !== {32'h2, 3'b001, 1'b1, 16'd2}) begin
            n_err++; $display("FAIL tmr_r1 got %h d=%b c=%b cnt=%0d want 2 001 1 2", voted_o, err_detected_o, err_corrected_o, corr_cnt_o);
        end
        vote(32'h7, 32'h9, 32'h7, 1'b0);
        n_vec++;
        if ({voted_o, err_detected_o, err_corrected_o, corr_cnt_o} !== {32'h7, 3'b010, 1'b1, 16'd3}) begin
            n_err++; $display("FAIL tmr_r2 got %h d=%b c=%b cnt=%0d want 7 010 1 3", voted_o, err_detected_o, err_corrected_o, corr_cnt_o);
        end
        vote(32'h11, 32'h22, 32'h33, 1'b0);
        n_vec++;
        if ({voted_o, err_detected_o, err_corrected_o, err_uncorrectable_o, corr_cnt_o} !== {32'h11, 3'b111, 1'b0, 1'b1, 16'd3}) begin
            n_err++; $display("FAIL tmr_alldiff got %h d=%b c=%b u=%b cnt=%0d want 11 111 0 1 3",
                              voted_o, err_detected_o, err_corrected_o, err_uncorrectable_o, corr_cnt_o);
        end
        vote(32'hCAFE, 32'hCAFE, 32'hCAFE, 1'b0);
        n_vec++;
        if ({voted_o, err_detected_o, err_corrected_o, err_uncorrectable_o} !== {32'hCAFE, 3'b000, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL tmr_equal got %h d=%b c=%b u=%b want cafe 000 0 0",
                              voted_o, err_detected_o, err_corrected_o, err_uncorrectable_o);
        end
    endtask

    task automatic test_fail_threshold;
        idle_cycle(1'b1);
        for (int i = 1; i <= 4; i++) begin
            vote(32'h55, 32'h66, 32'h55, 1'b0);
            n_vec++;
            if (err_detected_o !== 3'b010 || failed_o !== ((i == 4) ? 3'b010 : 3'b000)
                || mode_o !== ((i == 4) ? 2'd1 : 2'd0)) begin
                n_err++; $display("FAIL threshold_vote%0d got d=%b failed=%b mode=%0d", i, err_detected_o, failed_o, mode_o);
            end
        end
        vote(32'h55, 32'h66, 32'h55, 1'b0);
        n_vec++;
        if ({voted_o, err_detected_o, err_corrected_o, err_uncorrectable_o, corr_cnt_o} !== {32'h55, 3'b000, 1'b0, 1'b0, 16'd4}) begin
            n_err++; $display("FAIL dmr_excluded got %h d=%b c=%b u=%b cnt=%0d want 55 000 0 0 4",
                              voted_o, err_detected_o, err_corrected_o, err_uncorrectable_o, corr_cnt_o);
        end
    endtask

    task automatic test_dmr_mismatch;
        vote(32'h1, 32'h1, 32'h2, 1'b0);
        n_vec++;
        if ({voted_o, err_detected_o, err_corrected_o, err_uncorrectable_o, failed_o, mode_o} !== {32'h1, 3'b101, 1'b0, 1'b1, 3'b010, 2'd1}) begin
            n_err++; $display("FAIL dmr_mismatch got %h d=%b c=%b u=%b failed=%b mode=%0d want 1 101 0 1 010 1",
                              voted_o, err_detected_o, err_corrected_o, err_uncorrectable_o, failed_o, mode_o);
        end
    endtask

    task automatic test_clear_in_dmr;
        vote(32'h1, 32'h1, 32'h2, 1'b1);
        n_vec++;
        if ({voted_o, err_detected_o, err_corrected_o, err_uncorrectable_o} !== {32'h1, 3'b101, 1'b0, 1'b1}) begin
            n_err++; $display("FAIL clear_vote_mode got %h d=%b c=%b u=%b want 1 101 0 1",
                              voted_o, err_detected_o, err_corrected_o, err_uncorrectable_o);
        end
        n_vec++;
        if ({failed_o, mode_o, corr_cnt_o} !== {3'b000, 2'd0, 16'd0}) begin
            n_err++; $display("FAIL clear_state got failed=%b mode=%0d cnt=%0d want 000 0 0", failed_o, mode_o, corr_cnt_o);
        end
    endtask

    task automatic test_recover;
        idle_cycle(1'b1);
        for (int i = 0; i < 7; i++) begin
            if (i == 3) vote(32'h9, 32'h9, 32'h9, 1'b0);
            else        vote(32'h9, 32'h9, 32'h8, 1'b0);
        end
        n_vec++;
        if (failed_o !== 3'b000 || mode_o !== 2'd0) begin
            n_err++; $display("FAIL recover_nofail got failed=%b mode=%0d want 000 0", failed_o, mode_o);
        end
        vote(32'h9, 32'h9, 32'h8, 1'b0);
        n_vec++;
        if (failed_o !== 3'b100 || mode_o !== 2'd1) begin
            n_err++; $display("FAIL recover_fourth got failed=%b mode=%0d want 100 1", failed_o, mode_o);
        end
    endtask

    task automatic test_uncorr_no_count;
        idle_cycle(1'b1);
        for (int i = 0; i < 3; i++) vote(32'h3, 32'h3, 32'h4, 1'b0);
        vote(32'h3, 32'h5, 32'h4, 1'b0);
        n_vec++;
        if (failed_o !== 3'b000) begin n_err++; $display("FAIL uncorr_hold got failed=%b want 000", failed_o); end
        vote(32'h3, 32'h3, 32'h4, 1'b0);
        n_vec++;
        if (failed_o !== 3'b100) begin n_err++; $display("FAIL uncorr_keep_cnt got failed=%b want 100", failed_o); end
    endtask

    task automatic test_reset_midflight;
        idle_cycle(1'b1);
        vote(32'hF0, 32'hF1, 32'hF0, 1'b0);
        rst = 1'b1;
        vote(32'hF0, 32'hF1, 32'hF0, 1'b0);
        rst = 1'b0;
        n_vec++;
        if ({voted_o, valid_o, err_detected_o, err_corrected_o, err_uncorrectable_o, failed_o, mode_o, corr_cnt_o} !== 60'b0) begin
            n_err++; $display("FAIL rst_midflight got %h v=%b d=%b c=%b u=%b failed=%b mode=%0d cnt=%0d want all 0",
                              voted_o, valid_o, err_detected_o, err_corrected_o, err_uncorrectable_o, failed_o, mode_o, corr_cnt_o);
        end
        idle_cycle(1'b0);
        n_vec++;
        if (valid_o !== 1'b0) begin n_err++; $display("FAIL rst_no_valid got %b want 0", valid_o); end
        for (int i = 0; i < 3; i++) vote(32'hF0, 32'hF1, 32'hF0, 1'b0);
        n_vec++;
        if (failed_o !== 3'b000) begin n_err++; $display("FAIL rst_healthy got failed=%b want 000", failed_o); end
        vote(32'hF0, 32'hF1, 32'hF0, 1'b0);
        n_vec++;
        if (failed_o !== 3'b010) begin n_err++; $display("FAIL rst_recount got failed=%b want 010", failed_o); end
    endtask

    initial begin
        rst     = 1'b1;
        valid_i = 1'b0;
        clear_i = 1'b0;
        in_1_i  = '0;
        in_2_i  = '0;
        in_3_i  = '0;
        test_reset;
        test_tmr_vote;
        test_fail_threshold;
        test_dmr_mismatch;
        test_clear_in_dmr;
        test_recover;
        test_uncorr_no_count;
        test_reset_midflight;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cv32e40p_tmr_voter_mon.md
CV32E40P_TMR_VOTER_MON -- requirements
Module: cv32e40p_tmr_voter_mon

Interface
REQ-001 SHALL have parameter L1, default 32, meaning the outer data dimension.
REQ-002 SHALL have parameter L2, default 1, meaning the inner data dimension; data ports are [L1-1:0][L2-1:0].
REQ-003 SHALL have parameter ERR_TH, default 4, meaning consecutive mismatches (1..255) that mark a replica FAILED.
REQ-004 SHALL have parameter CNT_W, default 16, meaning the width of the corrected-event counter.
REQ-005 SHALL have ports: clk input 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have ports: rst input 1, reset, synchronous and active-high.
REQ-007 SHALL have ports: in_1_i, in_2_i, in_3_i input L1xL2, the replica results.
REQ-008 SHALL have ports: valid_i input 1, qualifying the replica inputs this cycle.
REQ-009 SHALL have ports: clear_i input 1, clearing all fault state and counters.
REQ-010 SHALL have ports: voted_o output L1xL2, the registered voted result.
REQ-011 SHALL have ports: valid_o output 1, qualifying voted_o.
REQ-012 SHALL have ports: err_detected_o output 3, per-replica disagreement with the vote (registered, valid with valid_o).
REQ-013 SHALL have ports: err_corrected_o output 1, err_uncorrectable_o output 1, both valid with valid_o.
REQ-014 SHALL have ports: failed_o output 3, sticky per-replica FAILED flags; mode_o output 2 (0=TMR, 1=DMR, 2=SIMPLEX).
REQ-015 SHALL have ports: corr_cnt_o output CNT_W, saturating count of corrected votes.

Function
REQ-016 SHALL register the vote: inputs sampled with valid_i=1 at edge N appear on voted_o and the error outputs with valid_o=1 after edge N, latency 1.
REQ-017 SHALL hold voted_o and clear valid_o, err_detected_o, err_corrected_o and err_uncorrectable_o when valid_i=0, with no state update.
REQ-018 SHALL derive the mode from the failed count: 0 -> TMR, 1 -> DMR, 2 or 3 -> SIMPLEX.
REQ-019 SHALL, in TMR, vote by majority over the whole word. All equal: no error. Exactly one replica differs: vote is the majority, that replica is flagged, corrected=1. All three differ: vote is in_1_i, all three are flagged, uncorrectable=1.
REQ-020 SHALL, in DMR, ignore the failed replica. Two healthy equal: vote is their value, no error. Two healthy differ: vote is the lower-index healthy replica, both healthy are flagged, uncorrectable=1.
REQ-021 SHALL, in SIMPLEX, output the lowest-index non-failed replica, or in_1_i if all have failed; no error flags; uncorrectable=1 on every valid cycle.
REQ-022 SHALL keep a per-replica state machine HEALTHY -> SUSPECT -> FAILED with a saturating mismatch counter of 8 bits.
REQ-023 SHALL drive the state machine as follows on each valid vote, only when the replica is flagged in TMR/DMR with a majority or corrected outcome:
  - Flagged: counter+1; HEALTHY -> SUSPECT.
  - Counter reaching ERR_TH: -> FAILED.
  - Non-flagged valid vote: counter=0; SUSPECT -> HEALTHY.
REQ-024 SHALL not change any replica counter on an uncorrectable vote (all-different TMR or DMR mismatch).
REQ-025 SHALL make FAILED sticky until clear_i or rst, and SHALL exclude a FAILED replica starting with the vote after the one that failed it.
REQ-026 SHALL increment corr_cnt_o on each vote with corrected=1 and saturate at all-ones without wrap.
REQ-027 SHALL, when clear_i=1, return all replicas to HEALTHY with counter 0, clear corr_cnt_o, and discard that cycle's state updates. A coincident valid_i vote still produces output using the pre-clear mode.
REQ-028 SHALL assert failed_o and mode_o from registered state only; no combinational path from inputs.

Reset
REQ-029 SHALL on rst=1 at a clock edge set voted_o=0 and valid_o=0. All error outputs, failed_o, mode_o and corr_cnt_o go to 0, all replicas to HEALTHY with counter 0.
REQ-030 SHALL give rst priority over clear_i and valid_i, and SHALL abort an in-flight vote so no valid_o follows the reset cycle.

Structure
REQ-031 SHALL place the mode enum (TMR/DMR/SIMPLEX) and the replica state enum (HEALTHY/SUSPECT/FAILED) in shared package cv32e40p_ft_pkg.
REQ-032 SHALL implement the per-replica counter and state machine in sub-module cv32e40p_voter_replica_mon, instantiated three times.

Verification
REQ-033 SHALL cover this scenario: TMR with in_1=in_2=0xA5A5A5A5, in_3=0xA5A5A5A4. Next cycle: voted_o=0xA5A5A5A5, err_detected_o=3'b100, corrected=1, corr_cnt_o=1.
REQ-034 SHALL cover this scenario: ERR_TH=4, in_2 corrupted on 4 consecutive valid votes. failed_o=3'b010 and mode_o=DMR after the 4th vote; the 5th vote with in_2 corrupt shows no flag.
REQ-035 SHALL cover this scenario: DMR (replica 2 failed) with in_1=0x1, in_3=0x2. voted_o=0x1, err_detected_o=3'b101, uncorrectable=1, counters unchanged.
REQ-036 SHALL cover this scenario: in_3 corrupted 3 times, 1 clean vote, then 3 more corrupted. in_3 never fails; its state returns to HEALTHY after the clean vote.
REQ-037 SHALL cover this scenario: clear_i together with valid_i while mode=DMR. Output uses DMR, and on the next cycle failed_o=0, mode_o=TMR, corr_cnt_o=0.
REQ-038 SHALL cover this scenario: rst asserted on the cycle after a valid vote while SUSPECT. valid_o=0, all outputs 0, and the replica is HEALTHY afterwards.
